// File: rtl/dl_arb_pkg.sv
// dl_arb_pkg: shared state encoding and index helpers for the round-robin arbiter
package dl_arb_pkg;
  typedef enum logic {S_IDLE, S_GRANT} arb_state_t;
  function automatic int rr_next_ptr(input int idx, input int num);
    return (idx == num - 1) ? 0 : idx + 1;
  endfunction
  function automatic logic [5:0] onehot_to_idx(input logic [63:0] oh);
    logic [5:0] idx;
    idx = '0;
    for (int i = 0; i < 64; i++) idx |= oh[i] ? 6'(i) : 6'd0;
    return idx;
  endfunction
endpackage

// File: rtl/dl_pri_encoder_lsb_np.sv
// dl_pri_encoder_lsb_np: WIDTH-input priority encoder, lowest set index wins
module dl_pri_encoder_lsb_np
  import dl_arb_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);
  logic [WIDTH-1:0] w_low;
  // two's-complement trick isolates the lowest set bit
  assign w_low = i_vec & (~i_vec + WIDTH'(1));
  assign o_any = |i_vec;
  assign o_idx = IDX_W'(onehot_to_idx(64'(w_low)));
endmodule

// File: rtl/dl_rr_arbiter_np.sv
// dl_rr_arbiter_np: round-robin arbiter with registered valid/ready grant
// Optional burst lock port enabled by DL_RR_ARBITER_LOCK_EN.
module dl_rr_arbiter_np
  import dl_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
`ifdef DL_RR_ARBITER_LOCK_EN
  input  logic               lock,
`endif
  output logic               gnt_valid,
  input  logic               gnt_ready,
  output logic [NUM_REQ-1:0] gnt_onehot,
  output logic [IDX_W-1:0]   gnt_idx
);
  arb_state_t r_state, w_state_nxt;
  logic [IDX_W-1:0] r_ptr, r_idx, w_ptr_nxt, w_m_idx, w_u_idx, w_win_idx;
  logic [NUM_REQ-1:0] r_onehot, w_masked;
  logic w_hs, w_lock, w_hold, w_m_any, w_u_any, w_load;
`ifdef DL_RR_ARBITER_LOCK_EN
  assign w_lock = lock;
`else
  assign w_lock = 1'b0;
`endif
  assign w_hs = (r_state == S_GRANT) & gnt_ready;
  assign w_hold = w_hs & w_lock & req[r_idx];
  assign w_ptr_nxt = (w_hs & ~w_lock) ? IDX_W'(rr_next_ptr(int'(r_idx), NUM_REQ)) : r_ptr;
  assign w_masked = req & ({NUM_REQ{1'b1}} << w_ptr_nxt);
  dl_pri_encoder_lsb_np #(.WIDTH(NUM_REQ)) u_enc_masked (
    .i_vec(w_masked),
    .o_idx(w_m_idx),
    .o_any(w_m_any)
  );
  dl_pri_encoder_lsb_np #(.WIDTH(NUM_REQ)) u_enc_req (
    .i_vec(req),
    .o_idx(w_u_idx),
    .o_any(w_u_any)
  );
  // a locked requester still asking keeps the grant ahead of everyone
  assign w_win_idx = w_hold ? r_idx : (w_m_any ? w_m_idx : w_u_idx);
  assign w_load = (r_state == S_IDLE) | w_hs;
  always_ff @(posedge clk) begin
    r_state <= rst ? S_IDLE : w_state_nxt;
  end
  always_comb begin
    w_state_nxt = w_load ? (w_u_any ? S_GRANT : S_IDLE) : r_state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr    <= '0;
      r_idx    <= '0;
      r_onehot <= '0;
    end else begin
      r_ptr <= w_ptr_nxt;
      if (w_load) begin
        r_idx    <= w_u_any ? w_win_idx : '0;
        r_onehot <= w_u_any ? NUM_REQ'(1) << w_win_idx : '0;
      end
    end
  end
  always_comb begin
    gnt_valid  = (r_state == S_GRANT);
    gnt_onehot = r_onehot;
    gnt_idx    = r_idx;
  end
endmodule

// File: tb/tb_dl_rr_arbiter_np.sv
// tb_dl_rr_arbiter_np: directed and random checks of 4- and 3-requester arbiters
module tb_dl_rr_arbiter_np;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req = '0;
  logic gnt_ready = 1'b0;
  logic lock = 1'b0;
  logic gv4, gv3;
  logic [3:0] oh4;
  logic [2:0] oh3;
  logic [1:0] ix4, ix3;
  int checks = 0;
  int failures = 0;
  int m_ptr[2], m_idx[2];
  bit m_val[2];
  int nreq[2] = '{4, 3};

  always #5 clk = ~clk;

  dl_rr_arbiter_np #(.NUM_REQ(4)) u_dut4 (
    .clk(clk), .rst(rst), .req(req),
`ifdef DL_RR_ARBITER_LOCK_EN
    .lock(lock),
`endif
    .gnt_valid(gv4), .gnt_ready(gnt_ready), .gnt_onehot(oh4), .gnt_idx(ix4)
  );
  dl_rr_arbiter_np #(.NUM_REQ(3)) u_dut3 (
    .clk(clk), .rst(rst), .req(req[2:0]),
`ifdef DL_RR_ARBITER_LOCK_EN
    .lock(lock),
`endif
    .gnt_valid(gv3), .gnt_ready(gnt_ready), .gnt_onehot(oh3), .gnt_idx(ix3)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference: priority walks ptr, ptr+1, ... modulo n; served requester moves ptr past it
  task automatic model_step(input int u, input logic r, input logic [3:0] rq, input logic rdy, input logic lk);
    int n;
    bit hs;
    logic [3:0] rqm;
    n = nreq[u];
    rqm = (u == 1) ? {1'b0, rq[2:0]} : rq;
    if (r) begin
      m_val[u] = 0; m_idx[u] = 0; m_ptr[u] = 0;
      return;
    end
    hs = m_val[u] && rdy;
    if (m_val[u] && !hs) return;
    if (hs && !lk) m_ptr[u] = (m_idx[u] + 1) % n;
    if (hs && lk && rqm[m_idx[u]]) return;
    m_val[u] = 0;
    m_idx[u] = 0;
    for (int k = 0; k < n; k++)
      if (!m_val[u] && rqm[(m_ptr[u] + k) % n]) begin
        m_val[u] = 1;
        m_idx[u] = (m_ptr[u] + k) % n;
      end
  endtask

  task automatic cyc(input logic r, input logic [3:0] rq, input logic rdy, input logic lk);
    logic lk_eff;
`ifdef DL_RR_ARBITER_LOCK_EN
    lk_eff = lk;
`else
    lk_eff = 1'b0;
`endif
    rst = r; req = rq; gnt_ready = rdy; lock = lk;
    @(posedge clk);
    model_step(0, r, rq, rdy, lk_eff);
    model_step(1, r, rq, rdy, lk_eff);
    #1;
    check("valid4", 64'(gv4), 64'(m_val[0]));
    check("idx4", 64'(ix4), m_val[0] ? 64'(m_idx[0]) : 64'd0);
    check("onehot4", 64'(oh4), m_val[0] ? (64'd1 << m_idx[0]) : 64'd0);
    check("valid3", 64'(gv3), 64'(m_val[1]));
    check("idx3", 64'(ix3), m_val[1] ? 64'(m_idx[1]) : 64'd0);
    check("onehot3", 64'(oh3), m_val[1] ? (64'd1 << m_idx[1]) : 64'd0);
    check("ptr3_range", 64'(u_dut3.r_ptr < 2'd3), 64'd1);
  endtask

  initial begin
    #2;
    cyc(1, 4'b1111, 1, 0);
    cyc(1, 4'b1111, 1, 0);
    check("reset_valid", 64'(gv4), 64'd0);
    check("reset_onehot", 64'(oh4), 64'd0);
    check("reset_idx", 64'(ix4), 64'd0);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 4'b1111, 1, 0);
      check("rot4_idx", 64'(ix4), 64'(k % 4));
      check("rot4_valid", 64'(gv4), 64'd1);
      check("rot3_idx", 64'(ix3), 64'(k % 3));
    end
    cyc(0, 4'b0000, 1, 0);
    cyc(0, 4'b0000, 1, 0);
    check("idle_valid", 64'(gv4), 64'd0);
    for (int k = 1; k <= 5; k++) begin
      cyc(0, (k <= 2) ? 4'b0100 : 4'b0000, 0, 0);
      check("sticky_onehot", 64'(oh4), 64'h4);
    end
    cyc(0, 4'b0000, 1, 0);
    check("accept_idle", 64'(gv4), 64'd0);
    cyc(0, 4'b0011, 0, 0);
    check("wrap_idx", 64'(ix4), 64'd0);
    cyc(0, 4'b0010, 1, 0);
    check("skip_idx", 64'(ix4), 64'd1);
`ifdef DL_RR_ARBITER_LOCK_EN
    cyc(1, 4'b0000, 0, 0);
    cyc(0, 4'b0011, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 4'b0011, 1, 1);
      check("lock_idx", 64'(ix4), 64'd0);
    end
    cyc(0, 4'b0011, 1, 0);
    check("unlock_idx", 64'(ix4), 64'd1);
`endif
    for (int k = 0; k < 600; k++)
      cyc($urandom_range(0, 39) == 0, 4'($urandom), $urandom_range(0, 2) != 0, 1'($urandom));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
